// File: rtl/bram_ring_reader_pkg.sv
// Shared ring-buffer types and pointer helpers, used by both reader and writer.
// Pointers carry one extra wrap bit above the RAM address.
package bram_ring_reader_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef logic [ADDR_W_DEF:0]   ptr_t;
  typedef logic [DATA_W_DEF-1:0] sample_t;

  // Modulo-2^(ADDR_W+1) distance from b forward to a.
  function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/bram_ring_reader_skid_fifo2.sv
// 2-entry register FIFO; push lands next edge, head is registered (entry 0).
// No internal backpressure: caller guarantees no push into a full FIFO without a pop.
module skid_fifo2 #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_dat,
  input  logic              i_pop,
  output logic [1:0]        o_cnt,
  output logic [DATA_W-1:0] o_head
);

  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_e0;
  logic [DATA_W-1:0] r_e1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= 2'd0;
      r_e0  <= '0;
      r_e1  <= '0;
    end else if (i_flush) begin
      r_cnt <= 2'd0;
    end else if (i_push && i_pop) begin
      // Count is unchanged; the new word goes behind whatever survives the pop.
      if (r_cnt == 2'd1) begin
        r_e0 <= i_push_dat;
      end else begin
        r_e0 <= r_e1;
        r_e1 <= i_push_dat;
      end
    end else if (i_push && (r_cnt != 2'd2)) begin
      if (r_cnt == 2'd0) begin
        r_e0 <= i_push_dat;
      end else begin
        r_e1 <= i_push_dat;
      end
      r_cnt <= r_cnt + 2'd1;
    end else if (i_pop && (r_cnt != 2'd0)) begin
      r_e0  <= r_e1;
      r_cnt <= r_cnt - 2'd1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_head = r_e0;

endmodule

// File: rtl/bram_ring_reader.sv
// Ring-buffer read side: issues 1-cycle BRAM reads into a 2-entry skid, 2-cycle latency.
// At most two words outstanding (skid + in flight); m_ready low stalls issue.
module bram_ring_reader
  import bram_ring_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W:0]   i_wr_ptr,
  output logic [ADDR_W:0]   o_rd_ptr,
  output logic              o_bram_ren,
  output logic [ADDR_W-1:0] o_bram_raddr,
  input  logic [DATA_W-1:0] i_bram_rdata,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  input  logic              i_flush,
  output logic [ADDR_W:0]   o_level,
  output logic              o_ovf
);

  logic [ADDR_W:0] r_iss_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] r_level;
  logic            r_inflight;
  logic            r_ovf;

  logic [ADDR_W:0] w_avail;
  logic [ADDR_W:0] w_unread;
  logic [1:0]      w_cnt;
  logic [1:0]      w_occ;
  logic            w_pop;
  logic            w_ren;
  logic            w_overrun;

  assign w_avail  = i_wr_ptr - r_iss_ptr;
  assign w_unread = i_wr_ptr - r_rd_ptr;
  assign w_pop    = o_m_valid & i_m_ready;
  // Occupancy after this edge if nothing new is issued; never exceeds 2.
  assign w_occ    = w_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_ren    = !i_rst && !i_flush && (w_avail != '0) && (w_occ < 2'd2);
  // Strictly more than a full ring of unread words.
  assign w_overrun = w_unread[ADDR_W] && (|w_unread[ADDR_W-1:0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_iss_ptr  <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_inflight <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (i_flush) begin
      r_iss_ptr  <= i_wr_ptr;
      r_rd_ptr   <= i_wr_ptr;
      r_level    <= '0;
      r_inflight <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_ren) begin
        r_iss_ptr <= r_iss_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_inflight <= w_ren;
      r_level    <= w_unread;
      if (w_overrun) begin
        r_ovf <= 1'b1;
      end
    end
  end

  skid_fifo2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (i_flush),
    .i_push     (r_inflight),
    .i_push_dat (i_bram_rdata),
    .i_pop      (w_pop),
    .o_cnt      (w_cnt),
    .o_head     (o_m_data)
  );

  assign o_m_valid    = (w_cnt != 2'd0);
  assign o_bram_ren   = w_ren;
  assign o_bram_raddr = r_iss_ptr[ADDR_W-1:0];
  assign o_rd_ptr     = r_rd_ptr;
  assign o_level      = r_level;
  assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_bram_ring_reader.sv
// Directed bench with a BRAM model and an expected-word scoreboard.
module tb_bram_ring_reader;

  logic        clk;
  logic        rst;
  logic [8:0]  wr_ptr;
  logic [8:0]  rd_ptr;
  logic        bram_ren;
  logic [7:0]  bram_raddr;
  logic [15:0] bram_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        flush;
  logic [8:0]  level;
  logic        ovf;

  logic [15:0] mem [256];

  int checks = 0;
  int failures = 0;
  int ren_cnt = 0;
  int beats = 0;
  int cycle = 0;
  int first_beat = -1;
  int last_beat = -1;
  int beats_before = 0;
  logic [15:0] exp_q [$];
  int raddr_q [$];
  logic [15:0] tmp_word;

  logic        s_valid, s_ready, s_flush, s_ren;
  logic [15:0] s_data;

  bram_ring_reader #(.ADDR_W(8), .DATA_W(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wr_ptr     (wr_ptr),
    .o_rd_ptr     (rd_ptr),
    .o_bram_ren   (bram_ren),
    .o_bram_raddr (bram_raddr),
    .i_bram_rdata (bram_rdata),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_m_data     (m_data),
    .i_flush      (flush),
    .o_level      (level),
    .o_ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_ren) bram_rdata <= mem[bram_raddr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge (inputs are stable then), then advance to just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    cycle++;
    if (!rst && s_valid && !s_ready && !s_flush) begin
      chk("stall_valid", {31'd0, m_valid}, 32'd1);
      chk("stall_data", {16'd0, m_data}, {16'd0, s_data});
    end
    s_valid = m_valid;
    s_ready = m_ready;
    s_flush = flush;
    s_data  = m_data;
    s_ren   = bram_ren;
    if (bram_ren) begin
      ren_cnt++;
      raddr_q.push_back(int'(bram_raddr));
    end
    if (!rst && !flush && m_valid && m_ready) begin
      beats++;
      if (first_beat < 0) first_beat = cycle;
      last_beat = cycle;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_beat observed=%0h expected=none", m_data);
      end
      if (exp_q.size() != 0) begin
        tmp_word = exp_q.pop_front();
        chk("beat_data", {16'd0, m_data}, {16'd0, tmp_word});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int start, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(16'(4096 + ((start + k) % 256)));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(4096 + i);
    rst = 1'b1; wr_ptr = 9'd0; m_ready = 1'b0; flush = 1'b0;
    s_valid = 1'b0; s_ready = 1'b0; s_flush = 1'b0; s_ren = 1'b0; s_data = 16'd0;
    #1;
    chk("rst_ren_async", {31'd0, bram_ren}, 32'd0);
    repeat (2) cyc();
    chk("rst_ren", {31'd0, bram_ren}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_valid", {31'd0, m_valid}, 32'd0);
      chk("idle_ren", {31'd0, bram_ren}, 32'd0);
    end
    chk("idle_rd_ptr", {23'd0, rd_ptr}, 32'd0);
    chk("idle_level", {23'd0, level}, 32'd0);
    chk("idle_ovf", {31'd0, ovf}, 32'd0);
    chk("idle_data", {16'd0, m_data}, 32'd0);

    // Four words streaming with m_ready high; 2-cycle latency
    ren_cnt = 0; beats = 0;
    m_ready = 1'b1; wr_ptr = 9'd4; push_words(0, 4);
    cyc();
    chk("lat_c1_valid", {31'd0, s_valid}, 32'd0);
    chk("lat_c1_ren", {31'd0, s_ren}, 32'd1);
    cyc();
    chk("lat_c2_valid", {31'd0, s_valid}, 32'd0);
    cyc();
    chk("lat_c3_valid", {31'd0, s_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stream_valid", {31'd0, s_valid}, 32'd1);
    end
    repeat (3) cyc();
    chk("stream_done_valid", {31'd0, m_valid}, 32'd0);
    chk("stream_rd_ptr", {23'd0, rd_ptr}, 32'd4);
    chk("stream_level", {23'd0, level}, 32'd0);
    chk("stream_ren_cnt", ren_cnt, 32'd4);
    chk("stream_beats", beats, 32'd4);
    chk("stream_q_empty", exp_q.size(), 32'd0);

    // Backpressure: only two reads go out, head holds
    rst = 1'b1; wr_ptr = 9'd0; m_ready = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    ren_cnt = 0; beats = 0; first_beat = -1;
    wr_ptr = 9'd10; push_words(0, 10);
    repeat (8) cyc();
    chk("bp_ren_cnt", ren_cnt, 32'd2);
    chk("bp_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_data", {16'd0, m_data}, 32'h1000);
    m_ready = 1'b1;
    for (int i = 0; i < 40 && beats < 10; i++) cyc();
    chk("bp_beats", beats, 32'd10);
    chk("bp_no_gaps", last_beat - first_beat, 32'd9);
    chk("bp_q_empty", exp_q.size(), 32'd0);
    repeat (3) cyc();
    chk("bp_rd_ptr", {23'd0, rd_ptr}, 32'd10);

    // Wrap-around from 0x0FE to 0x102
    m_ready = 1'b0; wr_ptr = 9'h0FE; flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    chk("wrap_start_rd_ptr", {23'd0, rd_ptr}, 32'h0FE);
    raddr_q.delete();
    m_ready = 1'b1; wr_ptr = 9'h102; push_words(254, 4);
    repeat (10) cyc();
    chk("wrap_raddr_cnt", raddr_q.size(), 32'd4);
    if (raddr_q.size() == 4) begin
      chk("wrap_raddr0", raddr_q[0], 32'hFE);
      chk("wrap_raddr1", raddr_q[1], 32'hFF);
      chk("wrap_raddr2", raddr_q[2], 32'h00);
      chk("wrap_raddr3", raddr_q[3], 32'h01);
    end
    chk("wrap_rd_ptr", {23'd0, rd_ptr}, 32'h102);
    chk("wrap_q_empty", exp_q.size(), 32'd0);

    // Flush mid-stream with a read in flight
    wr_ptr = 9'h108; push_words(2, 6);
    repeat (3) cyc();
    chk("flush_inflight", {31'd0, s_ren}, 32'd1);
    m_ready = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    exp_q.delete();
    chk("flush_valid", {31'd0, m_valid}, 32'd0);
    chk("flush_rd_ptr", {23'd0, rd_ptr}, 32'h108);
    chk("flush_level", {23'd0, level}, 32'd0);
    beats_before = beats;
    m_ready = 1'b1;
    repeat (5) cyc();
    chk("flush_no_leak", beats, beats_before);

    // Full ring is legal; one more word is an overrun
    m_ready = 1'b0; wr_ptr = 9'h008 + 9'h100 + 9'h100; push_words(8, 256);
    repeat (2) cyc();
    chk("full_ovf", {31'd0, ovf}, 32'd0);
    chk("full_level", {23'd0, level}, 32'h100);
    wr_ptr = 9'h009; push_words(8, 1);
    cyc();
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    m_ready = 1'b1;
    repeat (6) cyc();
    chk("ovf_hold", {31'd0, ovf}, 32'd1);
    m_ready = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    exp_q.delete();
    chk("ovf_clear", {31'd0, ovf}, 32'd0);
    chk("ovf_clear_rd_ptr", {23'd0, rd_ptr}, 32'h009);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
